// File: rtl/seg_scan_ctrl.sv
// Scans NDIG hex digits onto one shared active-low 7-seg bus with a blanking gap per slot.
// Outputs are registered; DIG_SEL first asserts BLANK_CYC edges after EN is seen in IDLE.
module seg_scan_ctrl #(
   parameter int NDIG      = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [4*NDIG-1:0] DIGVAL,
   input  logic [NDIG-1:0]   DP_IN,
   input  logic              LZ_SUPP,
   output logic [6:0]        SEG,
   output logic              DP,
   output logic [NDIG-1:0]   DIG_SEL,
   output logic              FRAME
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [NDIG-1:0] sel_q, sel_d;
   logic            frame_q, frame_d;

   logic [4*NDIG-1:0] digval_shr;
   logic [3:0]        cur_val;
   logic              upper_zero;
   logic [6:0]        cur_seg;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Current digit and everything above it, shifted down to bit 0.
   always_comb begin
      digval_shr = DIGVAL >> {idx_q, 2'b00};
      cur_val    = digval_shr[3:0];
      upper_zero = (digval_shr == '0);
      if (LZ_SUPP && (idx_q != '0) && upper_zero) begin
         cur_seg = 7'h7F;
      end else begin
         cur_seg = hex_to_seg(cur_val);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         sel_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!EN) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Digit data is captured only on the BLANK->SHOW edge and held through the slot.
   always_comb begin
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      sel_d   = '0;
      frame_d = 1'b0;
      if (state_d == ST_SHOW) begin
         if (state_q == ST_SHOW) begin
            seg_d = seg_q;
            dp_d  = dp_q;
            sel_d = sel_q;
         end else begin
            seg_d = cur_seg;
            dp_d  = ~DP_IN[idx_q];
            sel_d = NDIG'(1) << idx_q;
         end
      end
      frame_d = (state_q == ST_SHOW) && (state_d == ST_BLANK) && (idx_q == IDX_LAST);
   end

   assign SEG     = seg_q;
   assign DP      = dp_q;
   assign DIG_SEL = sel_q;
   assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: decode table, directed scan/LZ/tearing/EN/RST sequences,
// then random stimulus checked every cycle against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

   localparam int NDIG = 4;
   localparam int SD   = 8;
   localparam int BC   = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [15:0] DIGVAL;
   logic [3:0]  DP_IN;
   logic        LZ_SUPP;
   logic [6:0]  SEG;
   logic        DP;
   logic [3:0]  DIG_SEL;
   logic        FRAME;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .DIGVAL(DIGVAL), .DP_IN(DP_IN),
      .LZ_SUPP(LZ_SUPP), .SEG(SEG), .DP(DP), .DIG_SEL(DIG_SEL), .FRAME(FRAME)
   );

   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: edges elapsed since scanning started; slot/position fall out by division.
   bit         m_active = 1'b0;
   int         m_e      = 0;
   logic [6:0] m_seg    = 7'h7F;
   logic       m_dp     = 1'b1;

   function automatic logic [6:0] exp_digit_seg(input logic [15:0] dv, input logic lz, input int d);
      logic [15:0] hi;
      logic [3:0]  v;
      hi = dv >> (4 * d);
      v  = hi[3:0];
      if (lz && d > 0 && hi == 16'h0) return 7'h7F;
      return dec_tab[v];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int d;
      if (RST || !EN) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_e      = 0;
      end else begin
         m_e++;
         if (m_e % SD == BC) begin
            d     = (m_e / SD) % NDIG;
            m_seg = exp_digit_seg(DIGVAL, LZ_SUPP, d);
            m_dp  = ~DP_IN[d];
         end
      end
   endtask

   task automatic step();
      int pos, d;
      bit show, frm;
      @(posedge CLK);
      model_edge();
      #1;
      pos  = m_e % SD;
      d    = (m_e / SD) % NDIG;
      show = m_active && (pos >= BC);
      frm  = m_active && (m_e > 0) && (pos == 0) && (d == 0);
      chk("model_seg", SEG, show ? m_seg : 7'h7F);
      chk("model_dp", DP, show ? m_dp : 1'b1);
      chk("model_sel", DIG_SEL, show ? (4'b0001 << d) : 4'b0000);
      chk("model_frame", FRAME, frm);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      EN  = 1'b0;
      step();
      RST = 1'b0;
   endtask

   typedef struct {
      logic [15:0] digval;
      logic [3:0]  dp_in;
      logic        lz;
      logic [6:0]  exp_seg;
      logic        exp_dp;
   } vec_t;

   vec_t vecs [17];
   int   frames;

   initial begin
      vecs[0]  = '{16'h0000, 4'b0000, 1'b0, 7'h40, 1'b1};
      vecs[1]  = '{16'h0001, 4'b0001, 1'b1, 7'h79, 1'b0};
      vecs[2]  = '{16'hF002, 4'b0000, 1'b0, 7'h24, 1'b1};
      vecs[3]  = '{16'h0003, 4'b0000, 1'b1, 7'h30, 1'b1};
      vecs[4]  = '{16'h4444, 4'b1111, 1'b0, 7'h19, 1'b0};
      vecs[5]  = '{16'h0005, 4'b0000, 1'b1, 7'h12, 1'b1};
      vecs[6]  = '{16'h1236, 4'b0000, 1'b0, 7'h02, 1'b1};
      vecs[7]  = '{16'h0007, 4'b0000, 1'b1, 7'h78, 1'b1};
      vecs[8]  = '{16'h8888, 4'b0000, 1'b0, 7'h00, 1'b1};
      vecs[9]  = '{16'h0009, 4'b0000, 1'b1, 7'h10, 1'b1};
      vecs[10] = '{16'h000A, 4'b0000, 1'b0, 7'h08, 1'b1};
      vecs[11] = '{16'h765B, 4'b0000, 1'b1, 7'h03, 1'b1};
      vecs[12] = '{16'h000C, 4'b0000, 1'b0, 7'h46, 1'b1};
      vecs[13] = '{16'hABCD, 4'b0000, 1'b1, 7'h21, 1'b1};
      vecs[14] = '{16'h000E, 4'b0000, 1'b0, 7'h06, 1'b1};
      vecs[15] = '{16'h000F, 4'b1110, 1'b1, 7'h0E, 1'b1};
      vecs[16] = '{16'h0000, 4'b0001, 1'b1, 7'h40, 1'b0};

      DIGVAL = 16'h1234; DP_IN = 4'b0000; LZ_SUPP = 1'b0;

      // Reset held with EN high: everything stays blank.
      RST = 1'b1; EN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_seg", SEG, 7'h7F);
         chk("rst_dp", DP, 1'b1);
         chk("rst_sel", DIG_SEL, 4'b0000);
         chk("rst_frame", FRAME, 1'b0);
      end
      RST = 1'b0;

      // Scan order and frame rate.
      frames = 0;
      for (int e = 0; e <= 64; e++) begin
         step();
         if (FRAME) frames++;
         if (e == 1)  chk("scan_e1_sel", DIG_SEL, 4'b0000);
         if (e == 2)  begin chk("scan_d0_sel", DIG_SEL, 4'b0001); chk("scan_d0_seg", SEG, 7'h19); end
         if (e == 7)  chk("scan_d0_last", DIG_SEL, 4'b0001);
         if (e == 8)  chk("scan_gap_sel", DIG_SEL, 4'b0000);
         if (e == 10) begin chk("scan_d1_sel", DIG_SEL, 4'b0010); chk("scan_d1_seg", SEG, 7'h30); end
         if (e == 18) begin chk("scan_d2_sel", DIG_SEL, 4'b0100); chk("scan_d2_seg", SEG, 7'h24); end
         if (e == 26) begin chk("scan_d3_sel", DIG_SEL, 4'b1000); chk("scan_d3_seg", SEG, 7'h79); end
         if (e == 32) chk("scan_frame32", FRAME, 1'b1);
      end
      chk("scan_frame_count", frames, 2);

      // Leading-zero suppression and DP.
      do_reset();
      DIGVAL = 16'h0050; LZ_SUPP = 1'b1; DP_IN = 4'b0000; EN = 1'b1;
      for (int e = 0; e <= 58; e++) begin
         step();
         if (e == 2)  chk("lz_d0", SEG, 7'h40);
         if (e == 10) chk("lz_d1", SEG, 7'h12);
         if (e == 18) begin chk("lz_d2", SEG, 7'h7F); chk("lz_d2_sel", DIG_SEL, 4'b0100); end
         if (e == 26) begin chk("lz_d3", SEG, 7'h7F); chk("lz_d3_sel", DIG_SEL, 4'b1000); end
         if (e == 34) chk("lz0_d0", SEG, 7'h40);
         if (e == 42) chk("lz0_d1", SEG, 7'h7F);
         if (e == 50) begin chk("lz0_d2", SEG, 7'h7F); chk("lz0_d2_dp", DP, 1'b0); end
         if (e == 58) begin chk("lz0_d3", SEG, 7'h7F); chk("lz0_d3_dp", DP, 1'b1); end
         if (e == 30) begin DIGVAL = 16'h0000; DP_IN = 4'b0100; end
      end

      // Input change mid-SHOW must not tear the displayed digit.
      do_reset();
      DIGVAL = 16'h1234; LZ_SUPP = 1'b0; DP_IN = 4'b0000; EN = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         step();
         if (e >= 2 && e <= 7) chk("tear_hold", SEG, 7'h19);
         if (e == 10) begin chk("tear_next", SEG, 7'h46); chk("tear_next_sel", DIG_SEL, 4'b0010); end
         if (e == 5) DIGVAL = 16'hABCD;
      end

      // EN drop mid-SHOW of digit 2, then restart at digit 0 without FRAME.
      do_reset();
      DIGVAL = 16'h1234; EN = 1'b1;
      for (int e = 0; e <= 20; e++) begin
         step();
         if (e == 18) chk("endrop_d2", DIG_SEL, 4'b0100);
      end
      EN = 1'b0;
      step();
      chk("endrop_sel", DIG_SEL, 4'b0000);
      chk("endrop_seg", SEG, 7'h7F);
      step();
      EN = 1'b1;
      for (int e = 0; e <= 9; e++) begin
         step();
         chk("reen_noframe", FRAME, 1'b0);
         if (e == 1) chk("reen_e1", DIG_SEL, 4'b0000);
         if (e == 2) begin chk("reen_d0", DIG_SEL, 4'b0001); chk("reen_seg", SEG, 7'h19); end
      end

      // RST pulse mid-SHOW of digit 1.
      do_reset();
      DIGVAL = 16'h1234; EN = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         step();
         if (e == 10) chk("rstmid_d1", SEG, 7'h30);
      end
      RST = 1'b1;
      step();
      chk("rstmid_seg", SEG, 7'h7F);
      chk("rstmid_dp", DP, 1'b1);
      chk("rstmid_sel", DIG_SEL, 4'b0000);
      chk("rstmid_frame", FRAME, 1'b0);
      RST = 1'b0;
      for (int e = 0; e <= 2; e++) begin
         step();
         if (e == 2) begin chk("rstmid_d0", DIG_SEL, 4'b0001); chk("rstmid_d0seg", SEG, 7'h19); end
      end

      // Decode table on digit 0.
      foreach (vecs[i]) begin
         do_reset();
         DIGVAL = vecs[i].digval; DP_IN = vecs[i].dp_in; LZ_SUPP = vecs[i].lz; EN = 1'b1;
         for (int e = 0; e <= 2; e++) step();
         chk("vec_seg", SEG, vecs[i].exp_seg);
         chk("vec_dp", DP, vecs[i].exp_dp);
         chk("vec_sel", DIG_SEL, 4'b0001);
      end

      // Random stimulus against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         RST = ($urandom_range(0, 199) == 0);
         EN  = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 3) == 0) begin
            DIGVAL = 16'($urandom);
            if ($urandom_range(0, 1) == 1) DIGVAL = DIGVAL >> (4 * $urandom_range(1, 4));
         end
         DP_IN   = 4'($urandom);
         LZ_SUPP = 1'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
